// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: default requester count,
// index width and the two-state grant FSM encoding.
package arb_pkg;
    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = $clog2(ARB_N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage

// File: rtl/pe_onehot.sv
// MSB-first priority encoder: returns the highest set bit of i_vec as a
// one-hot vector, or zero when i_vec is zero.
module pe_onehot #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot
);
    always_comb begin
        o_onehot = '0;
        // Later (higher) indices overwrite earlier ones, so the MSB wins.
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, zero-bubble handoff and
// a per-grant hold limit of MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_gnt_idx, w_idx_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;

    logic [N-1:0]  w_mask, w_req_m, w_win_m, w_win_u, w_win;
    logic [IW-1:0] w_win_idx;
    logic          w_release;

    // Bits strictly below the last grantee get first pick on the next grant.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) w_mask[i] = (i < int'(r_ptr));
    end

    assign w_req_m = req & w_mask;

    pe_onehot #(.N(N)) u_pe_masked   (.i_vec(w_req_m), .o_onehot(w_win_m));
    pe_onehot #(.N(N)) u_pe_unmasked (.i_vec(req),     .o_onehot(w_win_u));

    assign w_win = (|w_req_m) ? w_win_m : w_win_u;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) w_win_idx = w_win_idx | IW'(i);
        end
    end

    // done, a dropped request and the hold limit all collapse into one release.
    assign w_release = (r_state == BUSY) &&
                       (done || !(|(req & r_gnt)) || (r_hold == HOLD_LAST));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        if ((r_state == IDLE || w_release) && (|req)) begin
            w_state_nxt = BUSY;
            w_gnt_nxt   = w_win;
            w_idx_nxt   = w_win_idx;
            w_ptr_nxt   = w_win_idx;
            w_hold_nxt  = '0;
        end else if (w_release) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
        end else if (r_state == BUSY && r_hold != HOLD_LAST) begin
            w_hold_nxt = r_hold + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign busy    = (r_state == BUSY);
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a rotating-priority reference model
// predicts each cycle's grant, a monitor compares after every clock edge.
module tb_rr_arbiter;
    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
    localparam int IW       = $clog2(N);
    localparam int STARVE   = (N - 1) * MAX_HOLD + 1;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          done = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          busy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    // Reference model: owner (-1 when idle), last grantee, cycles shown so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int wait_cnt[N];

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Priority order walks downward from the last grantee, wrapping, so the
    // last grantee itself comes last.
    function automatic int pick(input logic [N-1:0] r, input int p);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (p - k + N) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic step(input logic [N-1:0] r, input logic d, input bit rel_rst);
        exp_t e;
        int   w;
        bit   rel;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        req  = r;
        done = d;
        if (m_owner < 0) rel = 1'b1;
        else rel = d || !r[m_owner] || (m_held == MAX_HOLD);
        if (rel) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = w;
                m_held  = 1;
            end else begin
                m_owner = -1;
                m_held  = 0;
            end
        end else begin
            m_held++;
        end
        e.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.idx  = (m_owner >= 0) ? IW'(m_owner) : '0;
        e.busy = (m_owner >= 0);
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (gnt !== '0 || gnt_idx !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: gnt=%b idx=%0d busy=%b, want all zero", name, gnt, gnt_idx, busy);
        end
    endtask

    // Monitor: one prediction per edge, plus one-hot and starvation checks.
    initial begin
        exp_t e;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL grant @%0t: gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                             $time, gnt, gnt_idx, busy, e.gnt, e.idx, e.busy);
                end
                vectors++;
                if (!$onehot0(gnt) || (busy !== (gnt != '0))) begin
                    miscompares++;
                    $display("FAIL onehot @%0t: gnt=%b busy=%b, want one-hot/zero with busy=|gnt",
                             $time, gnt, busy);
                end
                for (int i = 0; i < N; i++) begin
                    if (req[i] && !gnt[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                end
                vectors++;
                for (int i = 0; i < N; i++) begin
                    if (wait_cnt[i] > STARVE) begin
                        miscompares++;
                        $display("FAIL starve @%0t: req %0d waited %0d cycles, limit %0d",
                                 $time, i, wait_cnt[i], STARVE);
                        wait_cnt[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rcur;
        // Power-on reset.
        #12;
        check_zero("reset");
        model_reset();

        // First grant on the first edge after release; MSB wins with ptr=0.
        step(8'b1010_0000, 1'b0, 1'b1);
        // Handoff order 7 -> 5 -> 0 -> 7 (wrap) on done pulses.
        step(8'b1010_0001, 1'b1, 1'b0);
        step(8'b1010_0001, 1'b1, 1'b0);
        step(8'b1010_0001, 1'b1, 1'b0);
        // Grantee drops with no other requester -> idle; done ignored in idle.
        step(8'b1000_0000, 1'b0, 1'b0);
        step(8'b0000_0000, 1'b0, 1'b0);
        step(8'b0000_0000, 1'b1, 1'b0);
        // Sole requester hits the hold limit and is re-granted with a fresh count;
        // a late competitor must wait out the full second hold window.
        for (int i = 0; i < 20; i++) step(8'b0000_0100, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(8'b0010_0100, 1'b0, 1'b0);
        // Non-granted line changes have no effect mid-grant.
        step(8'b1111_0000, 1'b1, 1'b0);
        step(8'b1011_0000, 1'b0, 1'b0);
        step(8'b1001_0000, 1'b0, 1'b0);

        // Asynchronous reset mid-grant.
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        step(8'hFF, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b0);

        // Randomized traffic with mostly-stable requests so hold limits occur.
        rcur = N'($urandom);
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(7) == 0) rcur = N'($urandom);
            if ($urandom_range(31) == 0) rcur[$urandom_range(N - 1)] = 1'b0;
            step(rcur, ($urandom_range(15) == 0), 1'b0);
        end

        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of requesters.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum number of consecutive cycles any single grant is held.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port req, input, N bits: per-requester request level.
REQ-006 The block SHALL have port done, input, 1 bit: current grantee releases the resource this cycle.
REQ-007 The block SHALL have port gnt, output, N bits, registered: one-hot grant, or all-zero when idle.
REQ-008 The block SHALL have port gnt_idx, output, $clog2(N) bits, registered: binary index of the set gnt bit; 0 when idle.
REQ-009 The block SHALL have port busy, output, 1 bit, registered: 1 iff gnt is nonzero.

Function
REQ-010 The block SHALL have two states: IDLE (gnt=0) and BUSY (gnt one-hot).
REQ-011 The block SHALL hold a last-grant pointer ptr (index); mask = bits with index strictly below ptr.
REQ-012 Winner selection SHALL be: if (req & mask) is nonzero, winner = MSB-first one-hot of (req & mask); otherwise winner = MSB-first one-hot of req.
REQ-013 In IDLE with req nonzero, the next edge SHALL load gnt=winner, move to BUSY, set ptr=winner index, and clear hold_cnt to 0.
REQ-014 In IDLE with req zero, the block SHALL remain in IDLE; done SHALL be ignored in IDLE.
REQ-015 In BUSY, hold_cnt SHALL increment by 1 each cycle the grant is held; it SHALL saturate at MAX_HOLD-1, with no wrap.
REQ-016 In BUSY, release SHALL occur when done=1, OR req[gnt_idx]=0, OR hold_cnt==MAX_HOLD-1; the resulting maximum grant length is exactly MAX_HOLD cycles.
REQ-017 On release with req nonzero, the same edge SHALL load the new winner (zero-bubble handoff), update ptr, and clear hold_cnt.
REQ-018 On release with req zero, the block SHALL go to IDLE with gnt=0 and ptr unchanged.
REQ-019 The current grantee SHALL have lowest priority on handoff and SHALL be re-granted only when it is the sole requester.
REQ-020 Latency SHALL be exactly one cycle from req sampled to gnt visible; gnt SHALL never have more than one bit set.
REQ-021 A req change on a non-granted line during BUSY SHALL have no effect until release.
REQ-022 Simultaneous done and hold-timeout SHALL count as a single release.

Reset
REQ-023 rst_n low SHALL immediately force gnt=0, gnt_idx=0, busy=0, state=IDLE, hold_cnt=0, ptr=0. With ptr=0 the mask is empty, so bit N-1 has highest priority after reset.
REQ-024 Reset asserted mid-grant SHALL abort the grant with no release handshake.
REQ-025 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 The shared package arb_pkg SHALL hold the N default, the index width, and the state enum (IDLE, BUSY).
REQ-027 The block SHALL instantiate the existing MSB-first one-hot priority encoder pe_onehot twice (masked and unmasked paths).
REQ-028 One-hot-to-index conversion SHALL be local combinational logic.
REQ-029 The block SHALL contain no other sub-modules.

Verification
REQ-030 Reset then req=8'b1010_0000 held -> gnt=8'b1000_0000, gnt_idx=7, busy=1 one cycle after.
REQ-031 Grant on bit 7, req=8'b1010_0001 held, done pulse -> next edge gnt=8'b0010_0000; next done -> 8'b0000_0001; next done -> 8'b1000_0000 (wrap).
REQ-032 Single requester req=8'b0000_0100, no done, MAX_HOLD=16 -> gnt held exactly 16 cycles, then re-granted to bit 2 with hold_cnt cleared.
REQ-033 Grantee drops its req while others are zero -> next edge gnt=0, busy=0, gnt_idx=0.
REQ-034 rst_n pulled low mid-BUSY -> outputs zero without waiting for an edge; after release, req=8'hFF -> gnt=8'b1000_0000.
REQ-035 Random req/done for 10k cycles -> gnt always one-hot or zero, and no requester starved longer than (N-1)*MAX_HOLD+1 cycles.
